vga_pipe_stage: RTL and testbench

VGA_PIPE_STAGE -- requirements
Module: vga_pipe_stage

---
 rtl/vga_pipe_pkg.sv | 18 +
 rtl/vga_pipe_slot.sv | 87 ++++++++
 rtl/vga_pipe_stage.sv | 86 ++++++++
 tb/tb_vga_pipe_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pipe_pkg.sv
// Shared definitions for the VGA pixel pipeline: depth limit, counter width
// helper and the packed RGB444 pixel layout carried in the payload.
package vga_pipe_pkg;

    localparam int DEPTH_MAX = 8;

    // Occupancy must represent 0..2*depth so the skid build fits too.
    function automatic int cnt_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_pipe_slot.sv
// One registered valid/ready pipeline slot. With VGA_PIPE_SKID_EN defined it
// adds a skid register so up_ready is a flop output; otherwise ready chains.
module vga_pipe_slot
    import vga_pipe_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;

    assign dn_valid = main_valid;
    assign dn_data  = main_data;

`ifdef VGA_PIPE_SKID_EN

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              main_free;
    logic              take_in;

    assign up_ready = !skid_valid;

    always_comb begin
        main_free = !main_valid || dn_ready;
        take_in   = up_valid && !skid_valid;
    end

    // The skid word is always older than any new input, since input is
    // refused while the skid register is occupied.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= take_in;
                if (take_in) begin
                    main_data <= up_data;
                end
            end
        end else if (take_in) begin
            skid_valid <= 1'b1;
            skid_data  <= up_data;
        end
    end

`else

    assign up_ready = !main_valid || dn_ready;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (up_ready) begin
            main_valid <= up_valid;
            if (up_valid) begin
                main_data <= up_data;
            end
        end
    end

`endif

endmodule

// File: rtl/vga_pipe_stage.sv
// DEPTH-slot registered valid/ready pipeline for VGA pixel payloads with flush
// and occupancy count. Define VGA_PIPE_SKID_EN for registered-ready skid slots.
module vga_pipe_stage
    import vga_pipe_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                      vga_clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]   occupancy
);

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int STAGES = (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;

    logic in_fire;
    logic out_fire;

    // Each generate scope owns its own handshake nets so the ready chain is
    // a set of distinct signals rather than one self-referencing vector.
    for (genvar g = 0; g < STAGES; g++) begin : stage
        logic              valid_q;
        logic              ready_in;
        logic [DATA_W-1:0] data_q;
        logic              prev_valid;
        logic [DATA_W-1:0] prev_data;
        logic              next_ready;

        if (g == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_body
            assign prev_valid = stage[g-1].valid_q;
            assign prev_data  = stage[g-1].data_q;
        end

        if (g == STAGES - 1) begin : g_tail
            assign next_ready = out_ready;
        end else begin : g_link
            assign next_ready = stage[g+1].ready_in;
        end

        vga_pipe_slot #(
            .DATA_W (DATA_W)
        ) slot (
            .vga_clk  (vga_clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (prev_valid),
            .up_ready (ready_in),
            .up_data  (prev_data),
            .dn_valid (valid_q),
            .dn_ready (next_ready),
            .dn_data  (data_q)
        );
    end

    // Input is refused while in reset and during the flush cycle.
    assign in_ready  = rst_n && !flush && stage[0].ready_in;
    assign out_valid = stage[STAGES-1].valid_q;
    assign out_data  = stage[STAGES-1].data_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vga_pipe_stage.sv
// Self-checking bench for vga_pipe_stage (DATA_W=24, DEPTH=4), default or
// VGA_PIPE_SKID_EN build, using a queue reference model of the pipeline.
module tb_vga_pipe_stage;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(2 * DEPTH + 1);
`ifdef VGA_PIPE_SKID_EN
    localparam int CAP  = 2 * DEPTH;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = DEPTH;
    localparam bit SKID = 1'b0;
`endif

    logic              vga_clk = 1'b0;
    logic              rst_n   = 1'b1;
    logic              flush   = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    int tick_n   = 0;

    logic [DATA_W-1:0] model_q[$];
    int                acc_t_q[$];
    logic              in_fire_s;
    logic              out_fire_s;
    logic [DATA_W-1:0] in_data_s;
    logic [DATA_W-1:0] out_data_s;

    vga_pipe_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge with inputs driven; samples handshakes, then
    // advances one rising edge and returns at the next falling edge.
    task automatic tick();
        #1;
        in_fire_s  = in_valid && in_ready;
        out_fire_s = out_valid && out_ready;
        in_data_s  = in_data;
        out_data_s = out_data;
        @(posedge vga_clk);
        @(negedge vga_clk);
        tick_n++;
    endtask

    task automatic model_update();
        if (out_fire_s && model_q.size() > 0) void'(model_q.pop_front());
        if (in_fire_s) model_q.push_back(in_data_s);
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge vga_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (occupancy !== '0) begin
            failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_data !== '0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
        @(negedge vga_clk);
        model_q.delete();
    endtask

    task automatic test_stream();
        int next = 1;
        int got  = 0;
        int t;
        acc_t_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 40 && got < 8; n++) begin
            in_valid = (next <= 8);
            in_data  = DATA_W'(next);
            t = tick_n;
            tick();
            if (out_fire_s) begin
                checks++;
                if (model_q.size() == 0 || out_data_s !== model_q[0]) begin
                    failures++;
                    $display("FAIL stream_data got=%h exp=%h", out_data_s,
                             (model_q.size() > 0) ? model_q[0] : '0);
                end
                checks++;
                if (acc_t_q.size() == 0 || t - acc_t_q[0] != DEPTH) begin
                    failures++;
                    $display("FAIL stream_latency got=%0d exp=%0d", t - ((acc_t_q.size() > 0) ? acc_t_q[0] : 0), DEPTH);
                end
                if (acc_t_q.size() > 0) void'(acc_t_q.pop_front());
                got++;
            end
            if (in_fire_s) begin
                acc_t_q.push_back(t);
                next++;
            end
            model_update();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8) begin
            failures++; $display("FAIL stream_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_fill();
        int sent = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2 * CAP + 8) begin
            in_data = DATA_W'(sent + 1);
            tick();
            if (in_fire_s) sent++;
            model_update();
            if (out_valid === 1'b1) begin
                checks++;
                if (model_q.size() == 0 || out_data !== model_q[0]) begin
                    failures++; $display("FAIL fill_hold got=%h exp=%h", out_data,
                                         (model_q.size() > 0) ? model_q[0] : '0);
                end
            end
        end
        checks++;
        if (sent != CAP) begin
            failures++; $display("FAIL fill_accepts got=%0d exp=%0d", sent, CAP);
        end
        checks++;
        if (occupancy !== CNT_W'(CAP)) begin
            failures++; $display("FAIL fill_occupancy got=%0d exp=%0d", occupancy, CAP);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_data !== 24'h000001) begin
            failures++; $display("FAIL fill_head got=%h exp=000001", out_data);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== !SKID) begin
            failures++; $display("FAIL full_ready_follow got=%b exp=%b", in_ready, !SKID);
        end
        for (int n = 0; n < 40 && model_q.size() > 0; n++) begin
            tick();
            if (out_fire_s) begin
                checks++;
                if (out_data_s !== model_q[0]) begin
                    failures++; $display("FAIL fill_drain got=%h exp=%h", out_data_s, model_q[0]);
                end
            end
            model_update();
        end
        checks++;
        if (model_q.size() != 0 || occupancy !== '0) begin
            failures++; $display("FAIL fill_drain_empty left=%0d occ=%0d exp=0", model_q.size(), occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DATA_W'(32'h0000A0 + i);
            tick();
            model_update();
        end
        in_valid = 1'b0;
        repeat (DEPTH + 2) begin
            tick();
            model_update();
        end
        checks++;
        if (occupancy !== CNT_W'(3) || out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_setup occ=%0d vld=%b exp occ=3 vld=1", occupancy, out_valid);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'hDEAD01;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (out_fire_s !== 1'b1 || out_data_s !== 24'h0000A0) begin
            failures++; $display("FAIL flush_head fire=%b data=%h exp fire=1 data=0000a0", out_fire_s, out_data_s);
        end
        checks++;
        if (in_fire_s !== 1'b0) begin
            failures++; $display("FAIL flush_no_accept got=%b exp=0", in_fire_s);
        end
        model_q.delete();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (occupancy !== '0) begin
            failures++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy);
        end
        repeat (DEPTH + 2) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL flush_stale got=%b data=%h exp=0", out_valid, out_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = DATA_W'($urandom);
            tick();
            if (out_fire_s) begin
                checks++;
                if (model_q.size() == 0 || out_data_s !== model_q[0]) begin
                    failures++;
                    $display("FAIL random_data got=%h exp=%h", out_data_s,
                             (model_q.size() > 0) ? model_q[0] : '0);
                end
            end
            model_update();
            checks++;
            if (occupancy !== CNT_W'(model_q.size()) || model_q.size() > CAP) begin
                failures++; $display("FAIL random_occupancy got=%0d exp=%0d", occupancy, model_q.size());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 4 * CAP && model_q.size() > 0; n++) begin
            tick();
            if (out_fire_s) begin
                checks++;
                if (out_data_s !== model_q[0]) begin
                    failures++; $display("FAIL random_drain got=%h exp=%h", out_data_s, model_q[0]);
                end
            end
            model_update();
        end
        checks++;
        if (model_q.size() != 0) begin
            failures++; $display("FAIL random_drain_left got=%0d exp=0", model_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DATA_W'(32'h000500 + i);
            tick();
            if (out_fire_s) begin
                checks++;
                if (out_data_s !== model_q[0]) begin
                    failures++; $display("FAIL midrst_pre got=%h exp=%h", out_data_s, model_q[0]);
                end
            end
            model_update();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            failures++; $display("FAIL midrst_async vld=%b occ=%0d exp 0/0", out_valid, occupancy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready);
        end
        model_q.delete();
        @(negedge vga_clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_release_ready got=%b exp=1", in_ready);
        end
        @(negedge vga_clk);
        in_valid = 1'b1;
        in_data  = 24'hC0FFEE;
        tick();
        model_update();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (out_fire_s) begin
                got++;
                checks++;
                if (out_data_s !== 24'hC0FFEE) begin
                    failures++; $display("FAIL midrst_first got=%h exp=c0ffee", out_data_s);
                end
            end
            model_update();
        end
        checks++;
        if (got != 1) begin
            failures++; $display("FAIL midrst_delivered got=%0d exp=1", got);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
